song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer_pkg.sv | 49 ++++
 rtl/song_rom.sv | 20 ++
 rtl/song_sequencer.sv | 150 +++++++++++++++
 tb/tb_song_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// Shared types and constants for the song sequencer: FSM encoding, ROM word layout,
// and the song table contents used by song_rom.
package song_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_WAIT   = 3'd4,
    ST_END    = 3'd5
  } state_e;

  localparam int          NOTE_W     = 6;
  localparam int          DUR_W      = 6;
  localparam int          WORD_W     = NOTE_W + DUR_W;
  localparam int          NOTE_MSB   = 11;
  localparam int          NOTE_LSB   = 6;
  localparam int          DUR_MSB    = 5;
  localparam int          DUR_LSB    = 0;
  localparam logic [5:0]  REST_NOTE  = 6'd0;
  localparam logic [5:0]  END_MARKER = 6'd0;

  // Song table; any entry not listed is a rest with the end-marker duration.
  function automatic logic [WORD_W-1:0] rom_entry(input int song, input int idx);
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
    note = REST_NOTE;
    dur  = END_MARKER;
    case (song)
      0: case (idx)
           0: begin note = 6'd5;  dur = 6'd2; end
           1: begin note = 6'd9;  dur = 6'd1; end
           2: begin note = 6'd12; dur = 6'd3; end
           default: ;
         endcase
      1: begin note = 6'(idx + 1); dur = 6'd1; end
      2: if (idx == 0) begin note = 6'd7; dur = 6'd1; end
      3: case (idx)
           0: begin note = 6'd20; dur = 6'd2; end
           1: begin note = 6'd21; dur = 6'd2; end
           default: ;
         endcase
      default: ;
    endcase
    return {note, dur};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Song ROM with a registered output: data for an address appears one cycle later.
module song_rom
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32
) (
  input  logic                                                  clk,
  input  logic [$clog2(NUM_SONGS)+$clog2(NOTES_PER_SONG)-1:0]   addr,
  output logic [WORD_W-1:0]                                     data
);

  localparam int IDX_W  = $clog2(NOTES_PER_SONG);
  localparam int ADDR_W = $clog2(NUM_SONGS) + IDX_W;

  always_ff @(posedge clk) begin
    data <= rom_entry(int'(addr[ADDR_W-1:IDX_W]), int'(addr[IDX_W-1:0]));
  end

endmodule

// File: rtl/song_sequencer.sv
// Steps through song ROM entries and hands note/duration pairs to the note player.
// Define SONG_LOOP_EN to make a finished song restart from entry 0 instead of idling.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS      = 4,
  parameter int NOTES_PER_SONG = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                play,
  input  logic                                next_song,
  input  logic                                done_with_note,
  output logic [5:0]                          note_to_load,
  output logic [5:0]                          duration_to_load,
  output logic                                load_new_note,
  output logic                                song_done,
  output logic [$clog2(NUM_SONGS)-1:0]        current_song,
  output logic [$clog2(NOTES_PER_SONG)-1:0]   note_index
);

  localparam int SONG_W = $clog2(NUM_SONGS);
  localparam int IDX_W  = $clog2(NOTES_PER_SONG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

  state_e              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic                load_q, load_d;
  logic                done_q, done_d;
  logic                pend_q, pend_d;
  logic [WORD_W-1:0]   rom_word;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  song_rom #(
    .NUM_SONGS      (NUM_SONGS),
    .NOTES_PER_SONG (NOTES_PER_SONG)
  ) u_rom (
    .clk  (clk),
    .addr ({song_q, idx_q}),
    .data (rom_word)
  );

  assign rom_note = rom_word[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = rom_word[DUR_MSB:DUR_LSB];

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    idx_d   = idx_q;
    note_d  = note_q;
    dur_d   = dur_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    pend_d  = pend_q;
    if (next_song) begin
      song_d  = song_q + 1'b1;
      idx_d   = '0;
      state_d = ST_IDLE;
      note_d  = REST_NOTE;
      dur_d   = END_MARKER;
      // A strobe already on the wire defers the silencing strobe by a cycle.
      if (load_q) begin
        pend_d = 1'b1;
      end else begin
        load_d = 1'b1;
        pend_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            note_d = REST_NOTE;
            dur_d  = END_MARKER;
            load_d = 1'b1;
            pend_d = 1'b0;
          end else if (play) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          if (rom_dur != END_MARKER) begin
            note_d  = rom_note;
            dur_d   = rom_dur;
            load_d  = 1'b1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_END;
          end
        end
        ST_SETTLE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (play && done_with_note) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = ST_END;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_END: begin
          done_d = 1'b1;
          idx_d  = '0;
`ifdef SONG_LOOP_EN
          state_d = ST_FETCH;
`else
          state_d = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      song_q  <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      dur_q   <= dur_d;
      load_q  <= load_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_q;
  assign song_done        = done_q;
  assign current_song     = song_q;
  assign note_index       = idx_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a small note-player model and a strobe monitor.
module tb_song_sequencer;
  import song_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic       next_song = 1'b0;
  logic       done_with_note;
  logic [5:0] note_to_load, duration_to_load;
  logic       load_new_note, song_done;
  logic [1:0] current_song;
  logic [4:0] note_index;

  logic       use_model = 1'b1;
  logic       done_force = 1'b0;
  logic [5:0] pcnt = 6'd0;
  logic       prev_load = 1'b0;
  int         strobe_cnt = 0, done_cnt = 0, dbl_cnt = 0;
  int         n_cmp = 0, n_err = 0;
  int         cyc, s0, d0;

  song_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .next_song        (next_song),
    .done_with_note   (done_with_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .song_done        (song_done),
    .current_song     (current_song),
    .note_index       (note_index)
  );

  always #5 clk = ~clk;

  // Player: counts the loaded duration down one per cycle while play is high.
  always @(posedge clk) begin
    if (reset) pcnt <= 6'd0;
    else if (load_new_note) pcnt <= duration_to_load;
    else if (play && pcnt != 6'd0) pcnt <= pcnt - 6'd1;
  end
  assign done_with_note = use_model ? (pcnt == 6'd0) : done_force;

  always @(posedge clk) begin
    if (load_new_note) strobe_cnt <= strobe_cnt + 1;
    if (song_done) done_cnt <= done_cnt + 1;
    if (load_new_note && prev_load) dbl_cnt <= dbl_cnt + 1;
    prev_load <= load_new_note;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; next_song = 1'b0; done_force = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int exp_note, input int exp_dur, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!load_new_note && n < 60);
    chk({tag, "_strobe"}, 32'(load_new_note), 1);
    chk({tag, "_note"}, 32'(note_to_load), exp_note);
    chk({tag, "_dur"}, 32'(duration_to_load), exp_dur);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!song_done && n < 60);
    chk({tag, "_song_done"}, 32'(song_done), 1);
  endtask

  task automatic pulse_next();
    next_song = 1'b1;
    @(negedge clk);
    next_song = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("rst_note", 32'(note_to_load), 0);
    chk("rst_dur", 32'(duration_to_load), 0);
    chk("rst_load", 32'(load_new_note), 0);
    chk("rst_done", 32'(song_done), 0);
    chk("rst_song", 32'(current_song), 0);
    chk("rst_idx", 32'(note_index), 0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Song 0: three notes then an end marker at entry 3.
    s0 = strobe_cnt; d0 = done_cnt;
    use_model = 1'b1;
    play = 1'b1;
    wait_strobe("s0_e0", 5, 2, cyc);
    chk("s0_first_latency", 32'(cyc - 1), 2);  // play is sampled at the first edge
    wait_strobe("s0_e1", 9, 1, cyc);
    chk("s0_gap_e0_e1", 32'(cyc), 6);
    wait_strobe("s0_e2", 12, 3, cyc);
    wait_done("s0");
    chk("s0_end_idx", 32'(note_index), 0);
`ifdef SONG_LOOP_EN
    chk("s0_end_state", 32'(dut.state_q), 32'(ST_FETCH));
    wait_strobe("s0_loop", 5, 2, cyc);
    chk("s0_loop_idx", 32'(note_index), 0);
    chk("s0_strobes", 32'(strobe_cnt - s0), 4);
    play = 1'b0;
`else
    chk("s0_end_state", 32'(dut.state_q), 32'(ST_IDLE));
    play = 1'b0;
    repeat (5) @(negedge clk);
    chk("s0_strobes", 32'(strobe_cnt - s0), 3);
    chk("s0_idle_hold", 32'(dut.state_q), 32'(ST_IDLE));
`endif
    chk("s0_done_count", 32'(done_cnt - d0), 1);

    // Pause in WAIT: done with play low must not advance.
    do_reset();
    use_model = 1'b0;
    play = 1'b1;
    wait_strobe("pause_e0", 5, 2, cyc);
    @(negedge clk);
    play = 1'b0; done_force = 1'b1;
    s0 = strobe_cnt;
    repeat (10) @(negedge clk);
    chk("pause_idx", 32'(note_index), 0);
    chk("pause_state", 32'(dut.state_q), 32'(ST_WAIT));
    chk("pause_strobes", 32'(strobe_cnt - s0), 0);
    play = 1'b1;
    @(negedge clk);
    chk("resume_idx", 32'(note_index), 1);
    chk("resume_state", 32'(dut.state_q), 32'(ST_FETCH));
    done_force = 1'b0;
    wait_strobe("resume_e1", 9, 1, cyc);

    // next_song wraps from 3 to 0 in WAIT, beating a simultaneous done.
    do_reset();
    next_song = 1'b1;
    @(negedge clk);
    next_song = 1'b0;
    chk("ns1_song", 32'(current_song), 1);
    chk("ns1_load", 32'(load_new_note), 1);
    chk("ns1_note", 32'(note_to_load), 0);
    chk("ns1_dur", 32'(duration_to_load), 0);
    @(negedge clk);
    pulse_next();
    pulse_next();
    chk("ns3_song", 32'(current_song), 3);
    play = 1'b1;
    wait_strobe("s3_e0", 20, 2, cyc);
    @(negedge clk);
    s0 = strobe_cnt; d0 = done_cnt;
    next_song = 1'b1; done_force = 1'b1;
    @(negedge clk);
    chk("wrap_song", 32'(current_song), 0);
    chk("wrap_load", 32'(load_new_note), 1);
    chk("wrap_note", 32'(note_to_load), 0);
    chk("wrap_dur", 32'(duration_to_load), 0);
    chk("wrap_idx", 32'(note_index), 0);
    chk("wrap_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("wrap_song_done", 32'(song_done), 0);
    next_song = 1'b0; done_force = 1'b0; play = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_strobes", 32'(strobe_cnt - s0), 1);
    chk("wrap_done_count", 32'(done_cnt - d0), 0);

    // next_song with play: silencing strobe first, FETCH the cycle after.
    next_song = 1'b1; play = 1'b1;
    @(negedge clk);
    next_song = 1'b0;
    chk("nsplay_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("nsplay_load", 32'(load_new_note), 1);
    chk("nsplay_song", 32'(current_song), 1);
    @(negedge clk);
    chk("nsplay_fetch", 32'(dut.state_q), 32'(ST_FETCH));
    chk("nsplay_noload", 32'(load_new_note), 0);
    wait_strobe("s1_e0", 1, 1, cyc);

    // next_song while a note strobe is on the wire: silencing strobe is deferred.
    next_song = 1'b1; play = 1'b0;
    @(negedge clk);
    next_song = 1'b0;
    chk("defer_load_low", 32'(load_new_note), 0);
    chk("defer_song", 32'(current_song), 2);
    @(negedge clk);
    chk("defer_load", 32'(load_new_note), 1);
    chk("defer_note", 32'(note_to_load), 0);
    chk("defer_dur", 32'(duration_to_load), 0);

    // Song 1: all 32 entries nonzero, ends on the index wrap.
    do_reset();
    pulse_next();
    use_model = 1'b1;
    s0 = strobe_cnt; d0 = done_cnt;
    play = 1'b1;
    for (int i = 0; i < 32; i++) wait_strobe($sformatf("s1_e%0d", i), i + 1, 1, cyc);
    wait_done("s1");
    chk("s1_end_idx", 32'(note_index), 0);
    chk("s1_strobes", 32'(strobe_cnt - s0), 32);
`ifdef SONG_LOOP_EN
    chk("s1_end_state", 32'(dut.state_q), 32'(ST_FETCH));
`else
    chk("s1_end_state", 32'(dut.state_q), 32'(ST_IDLE));
`endif
    play = 1'b0;

    // Reset during SETTLE clears everything on the next cycle.
    do_reset();
    use_model = 1'b0;
    play = 1'b1;
    wait_strobe("rs_e0", 5, 2, cyc);
    chk("rs_settle", 32'(dut.state_q), 32'(ST_SETTLE));
    reset = 1'b1;
    @(negedge clk);
    chk("rs_note", 32'(note_to_load), 0);
    chk("rs_dur", 32'(duration_to_load), 0);
    chk("rs_load", 32'(load_new_note), 0);
    chk("rs_done", 32'(song_done), 0);
    chk("rs_song", 32'(current_song), 0);
    chk("rs_idx", 32'(note_index), 0);
    chk("rs_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0; play = 1'b0;
    repeat (2) @(negedge clk);

    chk("no_back_to_back_load", 32'(dbl_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
